// File: rtl/jogo_memoria_param.sv
// Growing-sequence memory game: an LFSR fills the sequence, each round replays the
// prefix on the LEDs and then checks the player's answers key by key.
//
// state          | meaning
// ---------------+--------------------------------------------------------------
// inicial    (0) | idle after reset, waits for iniciar
// preparacao (1) | LFSR fills the sequence memory, one element per cycle
// mostra_aceso(2)| current element lit for T_MOSTRA cycles
// mostra_apagado(3)| dark gap of T_APAGADO cycles after each element
// espera_jogada(4)| keys echoed on leds, waiting for a press (timeout optional)
// espera_soltar(5)| waiting for all keys released
// compara    (6) | registered press checked against the expected element
// proxima_rodada(7)| round complete: win or grow the sequence by one
// fim_acerto (A) | game won
// fim_erro   (E) | wrong key
// fim_timeout(D) | player too slow
module jogo_memoria_param #(
    parameter int         N_CHAVES       = 4,
    parameter int         MAX_RODADAS    = 16,
    parameter int         T_MOSTRA       = 1000,
    parameter int         T_APAGADO      = 250,
    parameter int         TIMEOUT_CICLOS = 5000,
    parameter logic [7:0] SEMENTE        = 8'h01
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iniciar,
    input  logic [N_CHAVES-1:0]              chaves,
    input  logic [1:0]                       nivel_jogadas,
    input  logic                             nivel_tempo,
    output logic [N_CHAVES-1:0]              leds,
    output logic                             acertou,
    output logic                             errou,
    output logic                             timeout,
    output logic                             pronto,
    output logic [$clog2(MAX_RODADAS):0]     rodada,
    output logic [3:0]                       db_estado
);

    localparam int KW    = $clog2(N_CHAVES);
    localparam int IW    = $clog2(MAX_RODADAS);
    localparam int RW    = IW + 1;
    localparam int T_MAX = (T_MOSTRA > T_APAGADO) ? T_MOSTRA : T_APAGADO;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int OW    = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [3:0] {
        ST_INICIAL        = 4'h0,
        ST_PREPARACAO     = 4'h1,
        ST_MOSTRA_ACESO   = 4'h2,
        ST_MOSTRA_APAGADO = 4'h3,
        ST_ESPERA_JOGADA  = 4'h4,
        ST_ESPERA_SOLTAR  = 4'h5,
        ST_COMPARA        = 4'h6,
        ST_PROXIMA_RODADA = 4'h7,
        ST_FIM_ACERTO     = 4'hA,
        ST_FIM_TIMEOUT    = 4'hD,
        ST_FIM_ERRO       = 4'hE
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [RW-1:0]       rod_q, rod_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [OW-1:0]       to_q, to_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [N_CHAVES-1:0] jogada_q, jogada_d;
    logic [1:0]          nj_q, nj_d;
    logic                nt_q, nt_d;
    logic                pos_rodada_q, pos_rodada_d;

    logic [KW-1:0]       mem_q [MAX_RODADAS];
    logic                mem_we;

    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic                acertou_q, acertou_d;
    logic                errou_q, errou_d;
    logic                timeout_q, timeout_d;
    logic                pronto_q, pronto_d;
    logic [RW-1:0]       rodada_q, rodada_d;
    logic [3:0]          db_estado_q, db_estado_d;

    logic [7:0]          lfsr_step;
    logic [N_CHAVES-1:0] alvo;
    logic [RW-1:0]       limite;
    logic                mais;

    always_comb begin
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        alvo      = N_CHAVES'(1) << mem_q[idx_q];
        limite    = RW'(MAX_RODADAS / 4) * (RW'(nj_q) + RW'(1));
        mais      = (RW'(idx_q) + RW'(1)) < rod_q;
    end

    always_comb begin
        estado_d     = estado_q;
        idx_d        = idx_q;
        rod_d        = rod_q;
        tmr_d        = tmr_q;
        to_d         = to_q;
        lfsr_d       = lfsr_q;
        jogada_d     = jogada_q;
        nj_d         = nj_q;
        nt_d         = nt_q;
        pos_rodada_d = pos_rodada_q;
        mem_we       = 1'b0;

        case (estado_q)
            ST_INICIAL, ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT: begin
                if (iniciar) begin
                    estado_d = ST_PREPARACAO;
                    nj_d     = nivel_jogadas;
                    nt_d     = nivel_tempo;
                    lfsr_d   = SEMENTE;
                    idx_d    = '0;
                    rod_d    = '0;
                end
            end
            ST_PREPARACAO: begin
                lfsr_d = lfsr_step;
                mem_we = 1'b1;
                if (idx_q == IW'(MAX_RODADAS - 1)) begin
                    idx_d    = '0;
                    rod_d    = RW'(1);
                    tmr_d    = TW'(T_MOSTRA - 1);
                    estado_d = ST_MOSTRA_ACESO;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_MOSTRA_ACESO: begin
                if (tmr_q == '0) begin
                    tmr_d    = TW'(T_APAGADO - 1);
                    estado_d = ST_MOSTRA_APAGADO;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_MOSTRA_APAGADO: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (mais) begin
                    idx_d    = idx_q + IW'(1);
                    tmr_d    = TW'(T_MOSTRA - 1);
                    estado_d = ST_MOSTRA_ACESO;
                end else begin
                    idx_d    = '0;
                    to_d     = OW'(TIMEOUT_CICLOS - 1);
                    estado_d = ST_ESPERA_JOGADA;
                end
            end
            ST_ESPERA_JOGADA: begin
                // a press in the same cycle as the last idle tick still counts
                if (chaves != '0) begin
                    jogada_d = chaves;
                    estado_d = ST_COMPARA;
                end else if (nt_q) begin
                    if (to_q == '0) estado_d = ST_FIM_TIMEOUT;
                    else            to_d     = to_q - OW'(1);
                end
            end
            ST_COMPARA: begin
                if (jogada_q != alvo) begin
                    estado_d = ST_FIM_ERRO;
                end else if (mais) begin
                    idx_d        = idx_q + IW'(1);
                    pos_rodada_d = 1'b0;
                    estado_d     = ST_ESPERA_SOLTAR;
                end else begin
                    estado_d = ST_PROXIMA_RODADA;
                end
            end
            ST_PROXIMA_RODADA: begin
                if (rod_q == limite) begin
                    estado_d = ST_FIM_ACERTO;
                end else begin
                    rod_d        = rod_q + RW'(1);
                    idx_d        = '0;
                    pos_rodada_d = 1'b1;
                    estado_d     = ST_ESPERA_SOLTAR;
                end
            end
            ST_ESPERA_SOLTAR: begin
                // after a completed round the release only gates the next replay
                if (chaves == '0) begin
                    if (pos_rodada_q) begin
                        tmr_d    = TW'(T_MOSTRA - 1);
                        estado_d = ST_MOSTRA_ACESO;
                    end else begin
                        to_d     = OW'(TIMEOUT_CICLOS - 1);
                        estado_d = ST_ESPERA_JOGADA;
                    end
                end else if (nt_q && !pos_rodada_q) begin
                    if (to_q == '0) estado_d = ST_FIM_TIMEOUT;
                    else            to_d     = to_q - OW'(1);
                end
            end
            default: estado_d = ST_INICIAL;
        endcase
    end

    always_comb begin
        leds_d      = '0;
        acertou_d   = (estado_q == ST_FIM_ACERTO);
        errou_d     = (estado_q == ST_FIM_ERRO);
        timeout_d   = (estado_q == ST_FIM_TIMEOUT);
        pronto_d    = acertou_d || errou_d || timeout_d;
        rodada_d    = rod_q;
        db_estado_d = estado_q;
        if (estado_q == ST_MOSTRA_ACESO)  leds_d = alvo;
        if (estado_q == ST_ESPERA_JOGADA) leds_d = chaves;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= ST_INICIAL;
            idx_q        <= '0;
            rod_q        <= '0;
            tmr_q        <= '0;
            to_q         <= '0;
            lfsr_q       <= SEMENTE;
            jogada_q     <= '0;
            nj_q         <= '0;
            nt_q         <= 1'b0;
            pos_rodada_q <= 1'b0;
            leds_q       <= '0;
            acertou_q    <= 1'b0;
            errou_q      <= 1'b0;
            timeout_q    <= 1'b0;
            pronto_q     <= 1'b0;
            rodada_q     <= '0;
            db_estado_q  <= '0;
        end else begin
            estado_q     <= estado_d;
            idx_q        <= idx_d;
            rod_q        <= rod_d;
            tmr_q        <= tmr_d;
            to_q         <= to_d;
            lfsr_q       <= lfsr_d;
            jogada_q     <= jogada_d;
            nj_q         <= nj_d;
            nt_q         <= nt_d;
            pos_rodada_q <= pos_rodada_d;
            leds_q       <= leds_d;
            acertou_q    <= acertou_d;
            errou_q      <= errou_d;
            timeout_q    <= timeout_d;
            pronto_q     <= pronto_d;
            rodada_q     <= rodada_d;
            db_estado_q  <= db_estado_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[idx_q] <= lfsr_step[KW-1:0];
    end

    assign leds      = leds_q;
    assign acertou   = acertou_q;
    assign errou     = errou_q;
    assign timeout   = timeout_q;
    assign pronto    = pronto_q;
    assign rodada    = rodada_q;
    assign db_estado = db_estado_q;

endmodule

// File: doc/jogo_memoria_param.md
Name: jogo_memoria_param

Overview:
- Self-contained parametrised sequence-memory game (growing-sequence "Genius" style). Successor to the fixed 4-key, fixed-sequence circuit.
- Generates its own sequence with an LFSR and stores it internally.
- Each round replays the prefix on `leds`, then collects and checks the player's answers.
- Configurable: key count, maximum rounds, display/gap times, timeout, and four difficulty lengths. Sits under the board top level, which adds the hexa7seg displays.

Parameters:
- N_CHAVES, 4: number of keys/LEDs; power of 2, range 2..8.
- MAX_RODADAS, 16: sequence memory depth = longest game; multiple of 4.
- T_MOSTRA, 1000: cycles each element is lit during replay.
- T_APAGADO, 250: dark-gap cycles after each element.
- TIMEOUT_CICLOS, 5000: idle cycles allowed while waiting for a play.
- SEMENTE, 8'h01: LFSR seed, nonzero.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- iniciar  in  1  start/restart request, level-sampled.
- chaves  in  N_CHAVES  player keys, one-hot expected.
- nivel_jogadas  in  2  length select; limite = MAX_RODADAS*(nivel_jogadas+1)/4.
- nivel_tempo  in  1  1 = timeout enabled.
- leds  out  N_CHAVES  replay display / key echo.
- acertou  out  1  game won.
- errou  out  1  wrong play.
- timeout  out  1  player too slow.
- pronto  out  1  game ended.
- rodada  out  $clog2(MAX_RODADAS)+1  current round, 1-based; 0 when idle.
- db_estado  out  4  state code.

Behaviour:
- Reset (reset=0): state inicial; all outputs 0; counters and LFSR = SEMENTE; memory contents don't-care.
- States and db_estado codes: inicial 0, preparacao 1, mostra_aceso 2, mostra_apagado 3, espera_jogada 4, espera_soltar 5, compara 6, proxima_rodada 7, fim_acerto A, fim_erro E, fim_timeout D.
- inicial / fim_*:
  - iniciar=1 → preparacao.
  - nivel_jogadas and nivel_tempo are registered on this edge and held for the whole game.
  - On leaving, clear acertou/errou/timeout/pronto.
  - iniciar is ignored in every other state.
- preparacao (exactly MAX_RODADAS cycles):
  - LFSR reloads SEMENTE on entry.
  - Each cycle: step the LFSR (shift left, bit0 = b7^b5^b4^b3), then write mem[i] = new lfsr[$clog2(N_CHAVES)-1:0].
  - Exit: rodada=1, index=0 → mostra_aceso.
- mostra_aceso: leds = onehot(mem[index]) for T_MOSTRA cycles → mostra_apagado.
- mostra_apagado: leds=0 for T_APAGADO cycles. Then:
  - index<rodada-1: index++ → mostra_aceso.
  - otherwise: index=0, clear timeout counter → espera_jogada.
- espera_jogada:
  - leds = chaves (echo).
  - Play accepted when chaves≠0 → register chaves → compara (1 cycle).
  - Else, if nivel_tempo=1: counter++. Counter reaching TIMEOUT_CICLOS → fim_timeout.
  - Play and timeout in the same cycle: play wins.
- compara:
  - Registered play ≠ onehot(mem[index]), including any multi-hot value → fim_erro.
  - Else index<rodada-1: index++ → espera_soltar.
  - Else → proxima_rodada.
- espera_soltar:
  - Wait for chaves==0 → clear timeout counter → espera_jogada.
  - Timeout counter runs here too, with the same rule.
  - No new play is accepted until release.
- proxima_rodada:
  - rodada==limite → fim_acerto.
  - Else rodada++, index=0 → wait for chaves==0 (reuse espera_soltar semantics, counter disabled) → mostra_aceso.
- fim_*: pronto=1 plus the matching flag, held until iniciar; leds=0; rodada holds its final value.
- Outputs are registered (Moore); flags assert 1 cycle after entering the state.
- Reset mid-game: immediate return to inicial with all outputs 0.

Test Plan (bench params: N_CHAVES=4, MAX_RODADAS=4, T_MOSTRA=4, T_APAGADO=2, TIMEOUT_CICLOS=20, SEMENTE=8'h01):
- Sequence generation: reset, iniciar, nivel_jogadas=3 → mem = 2,0,0,1; round-1 leds 0100 for 4 cycles then 0000 for 2 cycles; rodada=1, db_estado 1→2→3→4.
- Full win: answer 0100 | 0100,0001 | 0100,0001,0001 | 0100,0001,0001,0010, releasing keys between plays → acertou=1, pronto=1, rodada=4, db_estado=A, held for 50 cycles.
- Error: round 2, second play 1000 → errou=1, pronto=1, db_estado=E. Also: multi-hot 0101 on round 1 → errou.
- Timeout: nivel_tempo=1, no key for 20 cycles in espera_jogada → timeout=1, db_estado=D. Same with nivel_tempo=0 → still in state 4 after 100 cycles.
- Short level: nivel_jogadas=0 (limite 1), play 0100 → acertou after round 1. Then iniciar → flags clear, game restarts with the same sequence 2,0,0,1.
- Async reset: reset=0 mid-replay with leds=0100 → all outputs 0 and db_estado=0 immediately, without waiting for a clock edge; iniciar ignored while in states 2–7.
